// File: rtl/sudoku_grid_checker_if.sv
// sudoku_grid_checker_if: load/edit/scan-control and status bundle for sudoku_grid_checker.
// With CONFLICT_LOC_EN defined it also carries the first-conflict location.
interface sudoku_grid_checker_if #(
   parameter int BOX = 3
);
   localparam int S = BOX*BOX;
   localparam int C = S*S;
   localparam int DW = $clog2(S+1);
   localparam int CW = $clog2(3*S+1);
   logic load;
   logic [C*DW-1:0] init_board;
   logic [C-1:0] init_blank;
   logic wr_req;
   logic [DW-1:0] wr_row;
   logic [DW-1:0] wr_col;
   logic [DW-1:0] wr_data;
   logic wr_ack;
   logic wr_rej;
   logic check_start;
   logic busy;
   logic done;
   logic valid;
   logic incomplete;
   logic [CW-1:0] conflict_cnt;
   logic [C*DW-1:0] board;
   logic [C-1:0] board_blank;
`ifdef CONFLICT_LOC_EN
   logic [1:0] first_conf_kind;
   logic [DW-1:0] first_conf_idx;
`endif
   modport master (
      output load, init_board, init_blank, wr_req, wr_row, wr_col, wr_data, check_start,
      input wr_ack, wr_rej, busy, done, valid, incomplete, conflict_cnt, board, board_blank
`ifdef CONFLICT_LOC_EN
      , first_conf_kind, first_conf_idx
`endif
   );
   modport slave (
      input load, init_board, init_blank, wr_req, wr_row, wr_col, wr_data, check_start,
      output wr_ack, wr_rej, busy, done, valid, incomplete, conflict_cnt, board, board_blank
`ifdef CONFLICT_LOC_EN
      , first_conf_kind, first_conf_idx
`endif
   );
endinterface

// File: rtl/sudoku_grid_checker.sv
// sudoku_grid_checker: Sudoku grid register with masked edits and a one-cell-per-cycle validator.
// Define CONFLICT_LOC_EN to also report the first conflicting group found by the scan.
module sudoku_grid_checker #(
   parameter int BOX = 3
) (
   input logic clk,
   input logic reset,
   sudoku_grid_checker_if.slave gc
);
   localparam int S = BOX*BOX;
   localparam int C = S*S;
   localparam int DW = $clog2(S+1);
   localparam int CW = $clog2(3*S+1);
   localparam int IW = $clog2(C);
   localparam logic [DW-1:0] BX = DW'(BOX);
   localparam logic [DW-1:0] SL = DW'(S-1);
   localparam logic [2:0] IDLE = 3'd0, ROWS = 3'd1, COLS = 3'd2, BOXES = 3'd3, FIN = 3'd4;
   logic [C*DW-1:0] board_q;
   logic [C-1:0] blank_q;
   logic [2:0] state_q;
   logic [DW-1:0] grp_q, cell_q;
   logic [S-1:0] seen_q;
   logic dup_q, inc_acc_q, ack_q, rej_q, done_q, valid_q, inc_q;
   logic [CW-1:0] conf_acc_q, cnt_q;
   logic busy, acc, restart, publish, last_cell, grp_dup, inc_d;
   logic [DW-1:0] r, c, v;
   logic [IW-1:0] widx, sidx;
   logic [S-1:0] onehot;
   logic [CW-1:0] conf_d;
   always_comb begin
      widx = IW'(gc.wr_row) * IW'(S) + IW'(gc.wr_col);
      acc = gc.wr_req && !gc.load && gc.wr_row <= SL && gc.wr_col <= SL && gc.wr_data <= DW'(S) && blank_q[widx];
      busy = state_q == ROWS || state_q == COLS || state_q == BOXES;
      restart = (gc.check_start && !gc.load) || (acc && busy);
      r = state_q == ROWS ? grp_q : state_q == COLS ? cell_q : grp_q / BX * BX + cell_q / BX;
      c = state_q == ROWS ? cell_q : state_q == COLS ? grp_q : grp_q % BX * BX + cell_q % BX;
      sidx = IW'(r) * IW'(S) + IW'(c);
      v = board_q[sidx*DW +: DW];
      onehot = (v != '0 && v <= DW'(S)) ? S'(1) << (v - 1'b1) : '0;
      grp_dup = dup_q || |(seen_q & onehot);
      last_cell = cell_q == SL;
      inc_d = inc_acc_q || v == '0;
      conf_d = conf_acc_q + CW'(last_cell && grp_dup);
      publish = busy && !gc.load && !restart && last_cell && grp_q == SL && state_q == BOXES;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         board_q <= '0;
         blank_q <= '0;
         state_q <= IDLE;
         grp_q <= '0;
         cell_q <= '0;
         seen_q <= '0;
         dup_q <= 1'b0;
         inc_acc_q <= 1'b0;
         conf_acc_q <= '0;
         ack_q <= 1'b0;
         rej_q <= 1'b0;
         done_q <= 1'b0;
         valid_q <= 1'b0;
         inc_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         ack_q <= acc;
         rej_q <= gc.wr_req && !acc;
         done_q <= publish;
         if (gc.load) begin
            board_q <= gc.init_board;
            blank_q <= gc.init_blank;
            state_q <= IDLE;
            valid_q <= 1'b0;
            inc_q <= 1'b0;
            cnt_q <= '0;
         end else begin
            if (acc) begin
               board_q[widx*DW +: DW] <= gc.wr_data;
               valid_q <= 1'b0;
            end
            // an edit during a scan restarts it so the result matches the final board
            if (restart) begin
               state_q <= ROWS;
               grp_q <= '0;
               cell_q <= '0;
               seen_q <= '0;
               dup_q <= 1'b0;
               inc_acc_q <= 1'b0;
               conf_acc_q <= '0;
            end else if (busy) begin
               cell_q <= last_cell ? '0 : cell_q + 1'b1;
               seen_q <= last_cell ? '0 : seen_q | onehot;
               dup_q <= !last_cell && grp_dup;
               inc_acc_q <= inc_d;
               conf_acc_q <= conf_d;
               grp_q <= !last_cell ? grp_q : grp_q == SL ? '0 : grp_q + 1'b1;
               state_q <= last_cell && grp_q == SL ? state_q + 3'd1 : state_q;
               if (publish) begin
                  valid_q <= !inc_d && conf_d == '0;
                  inc_q <= inc_d;
                  cnt_q <= conf_d;
               end
            end else if (state_q == FIN) begin
               state_q <= IDLE;
            end
         end
      end
   end
   assign gc.wr_ack = ack_q;
   assign gc.wr_rej = rej_q;
   assign gc.busy = busy;
   assign gc.done = done_q;
   assign gc.valid = valid_q;
   assign gc.incomplete = inc_q;
   assign gc.conflict_cnt = cnt_q;
   assign gc.board = board_q;
   assign gc.board_blank = blank_q;
`ifdef CONFLICT_LOC_EN
   logic [1:0] fk_acc_q, fk_q, fk_d;
   logic [DW-1:0] fi_acc_q, fi_q, fi_d;
   always_comb begin
      fk_d = fk_acc_q == 2'd3 && last_cell && grp_dup ? 2'(state_q - ROWS) : fk_acc_q;
      fi_d = fk_acc_q == 2'd3 && last_cell && grp_dup ? grp_q : fi_acc_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         fk_acc_q <= 2'd3;
         fi_acc_q <= '0;
         fk_q <= 2'd3;
         fi_q <= '0;
      end else if (restart) begin
         fk_acc_q <= 2'd3;
         fi_acc_q <= '0;
      end else if (busy && !gc.load) begin
         fk_acc_q <= fk_d;
         fi_acc_q <= fi_d;
         fk_q <= publish ? fk_d : fk_q;
         fi_q <= publish ? fi_d : fi_q;
      end
   end
   assign gc.first_conf_kind = fk_q;
   assign gc.first_conf_idx = fi_q;
`endif
endmodule

// File: tb/tb_sudoku_grid_checker.sv
// tb_sudoku_grid_checker: vector table, corner sequences and randomized boards against a group-count model.
module tb_sudoku_grid_checker;
   localparam int S = 9;
   localparam int C = 81;
   localparam int DW = 4;
   typedef struct {
      int r;
      int c;
      int d;
      bit ack;
      bit valid;
      bit inc;
      int cnt;
   } vec_t;
   logic clk = 1'b0;
   logic reset;
   int checks = 0;
   int failures = 0;
   int m[C];
   bit mb[C];
   vec_t tv[9];
   always #5 clk = ~clk;
   sudoku_grid_checker_if #(.BOX(3)) gc();
   sudoku_grid_checker_if #(.BOX(2)) gc2();
   sudoku_grid_checker #(.BOX(3)) dut (.clk(clk), .reset(reset), .gc(gc));
   sudoku_grid_checker #(.BOX(2)) dut2 (.clk(clk), .reset(reset), .gc(gc2));

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [C*DW-1:0] pack_board();
      logic [C*DW-1:0] p;
      for (int i = 0; i < C; i++) p[i*DW +: DW] = DW'(m[i]);
      return p;
   endfunction

   function automatic logic [C-1:0] pack_blank();
      logic [C-1:0] p;
      for (int i = 0; i < C; i++) p[i] = mb[i];
      return p;
   endfunction

   function automatic void set_solved();
      for (int r = 0; r < S; r++)
         for (int c = 0; c < S; c++) m[r*S+c] = (r*3 + r/3 + c) % S + 1;
   endfunction

   // groups scored by value histograms: any count above one is a conflict
   task automatic ref_check(output bit ok, output bit inc, output int cnt, output int fk, output int fi);
      inc = 0;
      cnt = 0;
      fk = 3;
      fi = 0;
      for (int kind = 0; kind < 3; kind++)
         for (int g = 0; g < S; g++) begin
            int hist[16];
            bit dup;
            dup = 0;
            for (int k = 0; k < 16; k++) hist[k] = 0;
            for (int k = 0; k < S; k++) begin
               int r, c;
               r = kind == 0 ? g : kind == 1 ? k : (g/3)*3 + k/3;
               c = kind == 0 ? k : kind == 1 ? g : (g%3)*3 + k%3;
               hist[m[r*S+c]]++;
            end
            if (hist[0] > 0) inc = 1;
            for (int k = 1; k <= S; k++) if (hist[k] > 1) dup = 1;
            if (dup) begin
               cnt++;
               if (fk == 3) begin
                  fk = kind;
                  fi = g;
               end
            end
         end
      ok = !inc && cnt == 0;
   endtask

   task automatic do_load(input bit with_start);
      gc.init_board = pack_board();
      gc.init_blank = pack_blank();
      gc.load = 1;
      gc.check_start = with_start;
      tick();
      gc.load = 0;
      gc.check_start = 0;
   endtask

   task automatic do_write(input string nm, input int r, input int c, input int d, input bit exp_ack);
      gc.wr_req = 1;
      gc.wr_row = DW'(r);
      gc.wr_col = DW'(c);
      gc.wr_data = DW'(d);
      tick();
      gc.wr_req = 0;
      chk({nm, "_ack"}, gc.wr_ack, exp_ack);
      chk({nm, "_rej"}, gc.wr_rej, !exp_ack);
      if (exp_ack) m[r*S+c] = d;
      chk({nm, "_board"}, int'(gc.board == pack_board()), 1);
   endtask

   task automatic cmp_model(input string nm);
      bit ok, inc;
      int cnt, fk, fi;
      ref_check(ok, inc, cnt, fk, fi);
      chk({nm, "_valid"}, gc.valid, ok);
      chk({nm, "_incomplete"}, gc.incomplete, inc);
      chk({nm, "_conflicts"}, gc.conflict_cnt, cnt);
`ifdef CONFLICT_LOC_EN
      chk({nm, "_kind"}, gc.first_conf_kind, fk);
      chk({nm, "_idx"}, gc.first_conf_idx, fi);
`endif
   endtask

   // ev: 0 restart by check_start, 1 accepted edit, 2 load; event driven in cycle T+at
   task automatic scan_evt(input string nm, input int ev, input int at, input int exp_lat);
      int n;
      bit busy_drop;
      busy_drop = 0;
      gc.check_start = 1;
      tick();
      gc.check_start = 0;
      n = 1;
      while (!gc.done && n < 600) begin
         if (n == at && ev == 0) gc.check_start = 1;
         if (n == at && ev == 1) begin
            gc.wr_req = 1;
            gc.wr_row = 0;
            gc.wr_col = 0;
            gc.wr_data = 1;
         end
         if (n == at && ev == 2) begin
            gc.init_board = pack_board();
            gc.init_blank = pack_blank();
            gc.load = 1;
         end
         tick();
         gc.check_start = 0;
         gc.wr_req = 0;
         gc.load = 0;
         if (n == at && ev == 1) chk({nm, "_ack"}, gc.wr_ack, 1);
         n++;
         if (!gc.busy && !gc.done) busy_drop = 1;
      end
      if (ev == 2) begin
         chk({nm, "_nodone"}, n, 600);
         chk({nm, "_busy"}, gc.busy, 0);
         chk({nm, "_valid"}, gc.valid, 0);
         chk({nm, "_busy_drop"}, busy_drop, 1);
      end else begin
         chk({nm, "_latency"}, n, exp_lat);
         chk({nm, "_busy_drop"}, busy_drop, 0);
         cmp_model(nm);
      end
   endtask

   task automatic run_scan(input string nm);
      scan_evt(nm, 0, -1, 244);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [47:0] b2;
      int n;
      reset = 1;
      gc.load = 0; gc.init_board = '0; gc.init_blank = '0; gc.wr_req = 0;
      gc.wr_row = 0; gc.wr_col = 0; gc.wr_data = 0; gc.check_start = 0;
      gc2.load = 0; gc2.init_board = '0; gc2.init_blank = '0; gc2.wr_req = 0;
      gc2.wr_row = 0; gc2.wr_col = 0; gc2.wr_data = 0; gc2.check_start = 0;
      tick();
      tick();
      chk("rst_busy", gc.busy, 0);
      chk("rst_done", gc.done, 0);
      chk("rst_valid", gc.valid, 0);
      chk("rst_incomplete", gc.incomplete, 0);
      chk("rst_conflicts", gc.conflict_cnt, 0);
      chk("rst_ack", gc.wr_ack, 0);
      chk("rst_rej", gc.wr_rej, 0);
      chk("rst_board", int'(gc.board == '0), 1);
      chk("rst_blank", int'(gc.board_blank == '0), 1);
`ifdef CONFLICT_LOC_EN
      chk("rst_kind", gc.first_conf_kind, 3);
      chk("rst_idx", gc.first_conf_idx, 0);
`endif
      reset = 0;
      tv[0] = '{0, 0, 2, 1, 0, 0, 3};
      tv[1] = '{0, 1, 5, 0, 1, 0, 0};
      tv[2] = '{0, 0, 10, 0, 1, 0, 0};
      tv[3] = '{4, 4, 0, 1, 0, 1, 0};
      tv[4] = '{9, 0, 1, 0, 1, 0, 0};
      tv[5] = '{0, 15, 3, 0, 1, 0, 0};
      tv[6] = '{8, 8, 1, 1, 0, 0, 3};
      tv[7] = '{8, 8, 8, 1, 1, 0, 0};
      tv[8] = '{4, 4, 10, 0, 1, 0, 0};
      for (int i = 0; i < 9; i++) begin
         set_solved();
         for (int k = 0; k < C; k++) mb[k] = 0;
         mb[0] = 1; mb[40] = 1; mb[80] = 1;
         do_load(0);
         do_write($sformatf("vec%0d", i), tv[i].r, tv[i].c, tv[i].d, tv[i].ack);
         run_scan($sformatf("vec%0d", i));
         chk($sformatf("vec%0d_tvalid", i), gc.valid, tv[i].valid);
         chk($sformatf("vec%0d_tinc", i), gc.incomplete, tv[i].inc);
         chk($sformatf("vec%0d_tcnt", i), gc.conflict_cnt, tv[i].cnt);
      end
      set_solved();
      do_load(0);
      scan_evt("restart_start", 0, 10, 254);
      scan_evt("restart_edit", 1, 100, 344);
      chk("pre_load_valid", gc.valid, 1);
      scan_evt("load_abort", 2, 50, 0);
      run_scan("after_abort");
      do_load(1);
      tick();
      chk("load_start_busy", gc.busy, 0);
      chk("load_start_valid", gc.valid, 0);
      for (int it = 0; it < 12; it++) begin
         set_solved();
         for (int k = 0; k < C; k++) mb[k] = ($urandom_range(0, 3) == 0);
         for (int k = $urandom_range(0, 3); k > 0; k--) m[$urandom_range(0, C-1)] = $urandom_range(0, 9);
         do_load(0);
         for (int e = 0; e < 3; e++) begin
            int r, c, d;
            r = $urandom_range(0, 10);
            c = $urandom_range(0, 10);
            d = $urandom_range(0, 11);
            do_write($sformatf("rnd%0d_w%0d", it, e), r, c, d, r < S && c < S && d <= S && mb[(r*S+c) % C]);
         end
         run_scan($sformatf("rnd%0d", it));
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) b2[(r*4+c)*3 +: 3] = 3'((r*2 + r/2 + c) % 4 + 1);
      gc2.init_board = b2;
      gc2.load = 1;
      tick();
      gc2.load = 0;
      gc2.check_start = 1;
      tick();
      gc2.check_start = 0;
      n = 1;
      while (!gc2.done && n < 200) begin
         tick();
         n++;
      end
      chk("box2_latency", n, 49);
      chk("box2_valid", gc2.valid, 1);
      chk("box2_incomplete", gc2.incomplete, 0);
      chk("box2_conflicts", gc2.conflict_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sudoku_grid_checker.md
Name: sudoku_grid_checker

Overview:
Parametrised successor to the game board register/validator. Holds an N²×N² Sudoku grid (box size BOX), accepts edit requests gated by a per-cell editable mask, and validates the grid with a sequential one-cell-per-cycle scanner instead of a flat combinational checker. Sits between the input front-end (keypad/mouse decode) and the display/game-state logic, and reports valid, incomplete and conflict status.

Parameters:
BOX, 3, box side; grid side S = BOX*BOX, cell count C = S*S
DW, $clog2(S+1), bits per cell; value 0 = empty, legal values 1..S
CW, $clog2(3*S+1), width of the conflict group counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
load  in  1  one-cycle pulse; copy init_board/init_blank into the grid
init_board  in  C*DW  cell (r,c) at bits [(r*S+c)*DW +: DW]
init_blank  in  C  bit r*S+c = 1 marks the cell editable
wr_req  in  1  edit request, single cycle
wr_row  in  DW  edit row, 0..S-1
wr_col  in  DW  edit column, 0..S-1
wr_data  in  DW  new value, 0..S (0 clears the cell)
wr_ack  out  1  one-cycle pulse, edit applied
wr_rej  out  1  one-cycle pulse, edit refused
check_start  in  1  one-cycle pulse; begin a validation scan
busy  out  1  scan in progress
done  out  1  one-cycle pulse, scan result published
valid  out  1  last published scan found no empty cell and no duplicate
incomplete  out  1  last published scan found at least one empty cell
conflict_cnt  out  CW  number of groups (rows+cols+boxes) containing a duplicate
board  out  C*DW  current grid, same packing as init_board
board_blank  out  C  current editable mask

Behaviour:
- Reset: board=0, board_blank=0, wr_ack=0, wr_rej=0, busy=0, done=0, valid=0, incomplete=0, conflict_cnt=0, FSM state IDLE.
- Load: takes effect the following cycle. Aborts any scan (FSM goes to IDLE, no done pulse). Clears valid, incomplete and conflict_cnt.
- Edit: wr_req sampled at cycle T. Response at T+1 is exactly one of wr_ack or wr_rej.
  - Reject if any of: wr_row≥S, wr_col≥S, wr_data>S, board_blank bit is 0, or load is asserted at T (load wins).
  - On ack: the cell is updated at T+1 and valid is cleared.
- Scan FSM states: IDLE → ROWS → COLS → BOXES → FIN → IDLE.
  - Each of ROWS/COLS/BOXES visits S groups × S cells, one cell per cycle.
  - BOXES order: box b = by*BOX+bx, cells visited row-major inside the box.
- Per-group bookkeeping:
  - Keep an S-bit seen mask, cleared at the start of each group.
  - Cell value 0 sets the incomplete accumulator.
  - Value v already marked in the mask sets the group's dup flag. Dup is counted once per group, even with multiple duplicates.
  - At the end of each group, conflict accumulator += dup.
- Timing:
  - check_start at T (in IDLE): busy=1 from T+1; cells are processed T+1..T+3C.
  - FIN at T+3C+1: done=1, and valid/incomplete/conflict_cnt update in the same cycle. busy drops at T+3C+1.
  - valid = (!incomplete_acc && conflict_acc==0).
- check_start while busy: restart the scan from ROWS group 0, cell 0 on the next cycle; done is delayed accordingly.
- Accepted edit while busy: same restart rule, so a published result always reflects the board as of the final restart.
- check_start coincident with load: load wins, and check_start is ignored.
- Outputs valid/incomplete/conflict_cnt hold between done pulses, except for the clears listed above.

Optional Feature:
CONFLICT_LOC_EN
- Defined: adds outputs first_conf_kind (2 bits: 0 row, 1 col, 2 box) and first_conf_idx (DW bits).
  - They latch the first group in scan order flagged dup.
  - They update with done; 3/0 when no conflict; reset to 3/0.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- BOX=3: load a solved grid, pulse check_start at T -> done at T+244, valid=1, incomplete=0, conflict_cnt=0.
- Solved grid with cell (0,0) editable: write value equal to cell (0,1), then scan -> wr_ack, valid=0, conflict_cnt=3. With CONFLICT_LOC_EN: kind=0, idx=0.
- Write to a locked cell, and write wr_data=10 to an editable cell -> wr_rej both times; board unchanged.
- Clear an editable cell (wr_data=0), then scan -> valid=0, incomplete=1, conflict_cnt=0.
- Start a scan, then make an accepted edit at T+100 -> busy stays 1, no done at T+244, done at T+100+244. Load mid-scan -> busy=0, no done pulse.
- BOX=2: load a solved 4×4 grid, check_start at T -> done at T+49, valid=1.
